// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - ID/EX-side bundle for the EX-stage multiply/divide unit
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             IStart;
    logic [5:0]       IFunct;
    logic [WIDTH-1:0] IDataA;
    logic [WIDTH-1:0] IDataB;
    logic             CAbort;
    logic             OBusy;
    logic             ODone;
    logic [WIDTH-1:0] OHi;
    logic [WIDTH-1:0] OLo;

    modport master (
        output IStart, IFunct, IDataA, IDataB, CAbort,
        input  OBusy, ODone, OHi, OLo
    );

    modport slave (
        input  IStart, IFunct, IDataA, IDataB, CAbort,
        output OBusy, ODone, OHi, OLo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative mult/div unit with HI/LO registers
// Magnitude shift-add / restoring division, sign fix-up in a final cycle.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic reset,
    ex_muldiv_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    // rem holds the upper product half (mult) or partial remainder (div);
    // quo holds the lower product half / shifting dividend-quotient.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             div_q, div_d;
    logic             dz_q, dz_d;

    logic               is_md, is_signed, is_div_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        is_md     = (bus.IFunct == F_MULT) || (bus.IFunct == F_MULTU) ||
                    (bus.IFunct == F_DIV)  || (bus.IFunct == F_DIVU);
        is_signed = (bus.IFunct == F_MULT) || (bus.IFunct == F_DIV);
        is_div_op = (bus.IFunct == F_DIV)  || (bus.IFunct == F_DIVU);
        a_neg     = is_signed & bus.IDataA[WIDTH-1];
        b_neg     = is_signed & bus.IDataB[WIDTH-1];
        a_mag     = a_neg ? -bus.IDataA : bus.IDataA;
        b_mag     = b_neg ? -bus.IDataB : bus.IDataB;

        mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[WIDTH-1:0] - b_q;

        prod      = {rem_q, quo_q};
        prod_fix  = neg_q ? -prod : prod;
        // Divide-by-zero leaves |A| in rem, so the remainder fix restores raw A.
        quo_fix   = dz_q ? '1 : (neg_q ? -quo_q : quo_q);
        rem_fix   = rneg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.IStart && !bus.CAbort) begin
                    if (is_md) begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        b_d     = b_mag;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        div_d   = is_div_op;
                        dz_d    = is_div_op && (bus.IDataB == '0);
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_ITER;
                    end else if (bus.IFunct == F_MTHI) begin
                        hi_d = bus.IDataA;
                    end else if (bus.IFunct == F_MTLO) begin
                        lo_d = bus.IDataA;
                    end
                end
            end
            S_ITER: begin
                if (bus.CAbort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (div_q) begin
                        rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], div_ge};
                    end else begin
                        rem_d = mul_sum[WIDTH:1];
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!bus.CAbort) begin
                    if (div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.OBusy = busy_q;
    assign bus.ODone = done_q;
    assign bus.OHi   = hi_q;
    assign bus.OLo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed vector bench for ex_muldiv_unit (WIDTH 32 and 8)
module tb_ex_muldiv_unit;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] m_hi, m_lo;

    ex_muldiv_if #(.WIDTH(32)) bus32 ();
    ex_muldiv_if #(.WIDTH(8))  bus8 ();

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus32));
    ex_muldiv_unit #(.WIDTH(8),  .CNT_W(4)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int inject_at);
        int n;
        int dn;
        bus32.IFunct = f;
        bus32.IDataA = a;
        bus32.IDataB = b;
        bus32.IStart = 1'b1;
        @(posedge clk); #1;
        bus32.IStart = 1'b0;
        chk({nm, " done low at accept"}, 64'(bus32.ODone), 64'd0);
        n = 0;
        dn = 0;
        while (bus32.OBusy && n < 100) begin
            n++;
            if (bus32.ODone) dn++;
            if (n == inject_at) begin
                bus32.IStart = 1'b1;
                bus32.IFunct = F_MTHI;
                bus32.IDataA = 32'hDEAD;
            end else begin
                bus32.IStart = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus32.IStart = 1'b0;
        chk({nm, " busy cycles"}, 64'(n), 64'd33);
        chk({nm, " no done while busy"}, 64'(dn), 64'd0);
        chk({nm, " done"}, 64'(bus32.ODone), 64'd1);
        chk({nm, " hi"}, 64'(bus32.OHi), 64'(ehi));
        chk({nm, " lo"}, 64'(bus32.OLo), 64'(elo));
        m_hi = ehi;
        m_lo = elo;
    endtask

    // Starts an op and raises CAbort once n busy cycles have been seen.
    task automatic start_abort(input string nm, input logic [5:0] f, input logic [31:0] a,
                               input logic [31:0] b, input int at);
        bus32.IFunct = f;
        bus32.IDataA = a;
        bus32.IDataB = b;
        bus32.IStart = 1'b1;
        @(posedge clk); #1;
        bus32.IStart = 1'b0;
        for (int k = 1; k < at; k++) begin
            @(posedge clk); #1;
        end
        chk({nm, " busy before abort"}, 64'(bus32.OBusy), 64'd1);
        bus32.CAbort = 1'b1;
        @(posedge clk); #1;
        bus32.CAbort = 1'b0;
        chk({nm, " busy after abort"}, 64'(bus32.OBusy), 64'd0);
        chk({nm, " done after abort"}, 64'(bus32.ODone), 64'd0);
        chk({nm, " hi kept"}, 64'(bus32.OHi), 64'(m_hi));
        chk({nm, " lo kept"}, 64'(bus32.OLo), 64'(m_lo));
        @(posedge clk); #1;
        chk({nm, " no late done"}, 64'(bus32.ODone), 64'd0);
    endtask

    task automatic run8(input string nm, input logic [5:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo);
        int n;
        bus8.IFunct = f;
        bus8.IDataA = a;
        bus8.IDataB = b;
        bus8.IStart = 1'b1;
        @(posedge clk); #1;
        bus8.IStart = 1'b0;
        n = 0;
        while (bus8.OBusy && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        chk({nm, " busy cycles"}, 64'(n), 64'd9);
        chk({nm, " done"}, 64'(bus8.ODone), 64'd1);
        chk({nm, " hi"}, 64'(bus8.OHi), 64'(ehi));
        chk({nm, " lo"}, 64'(bus8.OLo), 64'(elo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[14];
        vt[0]  = '{"mult -3*5",        F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[1]  = '{"multu max*max",    F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[2]  = '{"div -7/2",         F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[3]  = '{"div min/-1",       F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[4]  = '{"divu 7/0",         F_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
        vt[5]  = '{"divu 100/7",       F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vt[6]  = '{"mult 7*-3",        F_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vt[7]  = '{"mult -4*-6",       F_MULT,  32'hFFFFFFFC, 32'hFFFFFFFA, 32'h00000000, 32'h00000018};
        vt[8]  = '{"div 7/-2",         F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vt[9]  = '{"div -7/0",         F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vt[10] = '{"multu min*2",      F_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
        vt[11] = '{"div min/0",        F_DIV,   32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF};
        vt[12] = '{"multu x*16",       F_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
        vt[13] = '{"divu max/16",      F_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};

        bus32.IStart = 1'b0; bus32.IFunct = '0; bus32.IDataA = '0; bus32.IDataB = '0; bus32.CAbort = 1'b0;
        bus8.IStart = 1'b0;  bus8.IFunct = '0;  bus8.IDataA = '0;  bus8.IDataB = '0;  bus8.CAbort = 1'b0;
        m_hi = '0;
        m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset busy", 64'(bus32.OBusy), 64'd0);
        chk("reset done", 64'(bus32.ODone), 64'd0);
        chk("reset hi", 64'(bus32.OHi), 64'd0);
        chk("reset lo", 64'(bus32.OLo), 64'd0);

        // Back-to-back: each vector is accepted on the edge after the previous ODone.
        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].nm, vt[i].f, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, 0);
        end

        run_op("multu pre-mthi", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        bus32.IStart = 1'b1; bus32.IFunct = F_MTHI; bus32.IDataA = 32'h1234;
        @(posedge clk); #1;
        bus32.IStart = 1'b0;
        chk("mthi hi", 64'(bus32.OHi), 64'h1234);
        chk("mthi lo kept", 64'(bus32.OLo), 64'h1);
        chk("mthi busy", 64'(bus32.OBusy), 64'd0);
        chk("mthi no done", 64'(bus32.ODone), 64'd0);
        bus32.IStart = 1'b1; bus32.IFunct = F_MTLO; bus32.IDataA = 32'hABCD;
        @(posedge clk); #1;
        bus32.IStart = 1'b0;
        chk("mtlo lo", 64'(bus32.OLo), 64'hABCD);
        chk("mtlo hi kept", 64'(bus32.OHi), 64'h1234);
        m_hi = 32'h1234;
        m_lo = 32'hABCD;

        bus32.IStart = 1'b1; bus32.IFunct = 6'h10; bus32.IDataA = 32'h77;
        @(posedge clk); #1;
        bus32.IStart = 1'b0;
        chk("other funct busy", 64'(bus32.OBusy), 64'd0);
        chk("other funct hi", 64'(bus32.OHi), 64'(m_hi));

        bus32.IStart = 1'b1; bus32.IFunct = F_MTHI; bus32.IDataA = 32'h5555; bus32.CAbort = 1'b1;
        @(posedge clk); #1;
        bus32.IStart = 1'b0; bus32.CAbort = 1'b0;
        chk("abort idle mthi", 64'(bus32.OHi), 64'(m_hi));
        bus32.IStart = 1'b1; bus32.IFunct = F_MULT; bus32.IDataA = 32'd3; bus32.IDataB = 32'd3; bus32.CAbort = 1'b1;
        @(posedge clk); #1;
        bus32.IStart = 1'b0; bus32.CAbort = 1'b0;
        chk("abort idle mult busy", 64'(bus32.OBusy), 64'd0);

        start_abort("abort iter", F_DIVU, 32'd100, 32'd7, 10);
        run_op("divu after abort", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        start_abort("abort fix", F_MULT, 32'd9, 32'd9, 33);

        run_op("istart while busy", F_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        @(posedge clk); #1;
        chk("istart while busy hi", 64'(bus32.OHi), 64'd0);

        bus32.IFunct = F_MULTU; bus32.IDataA = 32'hFFFF; bus32.IDataB = 32'hFFFF; bus32.IStart = 1'b1;
        @(posedge clk); #1;
        bus32.IStart = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk); #1;
        end
        bus32.IStart = 1'b1;
        reset = 1'b0;
        #1;
        chk("async reset busy", 64'(bus32.OBusy), 64'd0);
        chk("async reset done", 64'(bus32.ODone), 64'd0);
        chk("async reset hi", 64'(bus32.OHi), 64'd0);
        chk("async reset lo", 64'(bus32.OLo), 64'd0);
        @(posedge clk); #1;
        chk("istart during reset", 64'(bus32.OBusy), 64'd0);
        bus32.IStart = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post reset idle", 64'(bus32.OBusy), 64'd0);
        run_op("divu after reset", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);

        run8("w8 mult -3*5",   F_MULT,  8'hFD, 8'h05, 8'hFF, 8'hF1);
        run8("w8 divu 100/7",  F_DIVU,  8'd100, 8'd7, 8'd2,  8'd14);
        run8("w8 div min/-1",  F_DIV,   8'h80, 8'hFF, 8'h00, 8'h80);
        run8("w8 multu ff*ff", F_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        run8("w8 divu 5/0",    F_DIVU,  8'd5,  8'd0,  8'd5,  8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
